// File: rtl/clock_view_pkg.sv
// Shared types for the clock display path: BCD digit type, blank code
// and the view/edit state encoding.
package clock_view_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BLANK_CODE = 4'hF;

    typedef enum logic {
        VIEW = 1'b0,
        EDIT = 1'b1
    } view_state_t;

endpackage

// File: rtl/clock_view_mux_blink_gen.sv
// Blink phase generator: counts 0..BLINK_DIV-1 and toggles the phase on wrap.
// Ports: clk, reset (sync, active-high), restart (clear count, force
// visible), blink (1 = digit visible).
module blink_gen #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic blink
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_blink;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_cnt   <= '0;
            r_blink <= 1'b1;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign blink = r_blink;

endmodule

// File: rtl/clock_view_mux.sv
// Registered display window mux with edit cursor and blinking cursor digit.
// Ports: clk, reset (sync, active-high), bcd_in[4*N_DIGITS], view_next,
//   edit_en, edit_next in; bcd_out[4*N_VIEW], edit_sel[N_DIGITS],
//   win_idx, blink out.
// Option: define LEADING_ZERO_BLANK_EN to blank a leading zero in window 0.
module clock_view_mux
    import clock_view_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int N_VIEW    = 4,
    parameter int STEP      = 2,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  view_next,
    input  logic                  edit_en,
    input  logic                  edit_next,
    output logic [4*N_VIEW-1:0]   bcd_out,
    output logic [N_DIGITS-1:0]   edit_sel,
    output logic [((((N_DIGITS-N_VIEW)/((STEP>0)?STEP:1))+1) > 1 ?
                   $clog2(((N_DIGITS-N_VIEW)/((STEP>0)?STEP:1))+1) : 1)-1:0]
                                  win_idx,
    output logic                  blink
);

    localparam int SSTEP = (STEP > 0) ? STEP : 1;
    localparam int NW    = (N_DIGITS - N_VIEW) / SSTEP + 1;
    localparam int WW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int CUW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [WW-1:0]  WIN_LAST = WW'(NW - 1);
    localparam logic [CUW-1:0] CUR_MSD  = CUW'(N_DIGITS - 1);

    if (N_VIEW < 1 || N_VIEW > N_DIGITS) begin : g_chk_view
        $error("clock_view_mux: N_VIEW must be 1..N_DIGITS");
    end
    if (STEP < 1) begin : g_chk_step
        $error("clock_view_mux: STEP must be >= 1");
    end else if ((N_DIGITS - N_VIEW) % STEP != 0) begin : g_chk_mod
        $error("clock_view_mux: (N_DIGITS-N_VIEW) not a multiple of STEP");
    end
    if (BLINK_DIV < 2) begin : g_chk_div
        $error("clock_view_mux: BLINK_DIV must be >= 2");
    end

    function automatic int f_base(input int w);
        return N_DIGITS - N_VIEW - w * SSTEP;
    endfunction

    // Windows overlap when STEP < N_VIEW; scanning downwards leaves the
    // smallest (most significant) window that still contains the cursor.
    function automatic logic [WW-1:0] f_win_of(input int c);
        logic [WW-1:0] w_res;
        w_res = '0;
        for (int w = NW - 1; w >= 0; w--) begin
            if (c >= f_base(w) && c <= f_base(w) + N_VIEW - 1) begin
                w_res = WW'(w);
            end
        end
        return w_res;
    endfunction

    view_state_t        r_state;
    view_state_t        w_state_nxt;
    logic [WW-1:0]      r_win;
    logic [WW-1:0]      w_win_nxt;
    logic [CUW-1:0]     r_cursor;
    logic [CUW-1:0]     w_cursor_nxt;
    logic               w_restart;
    logic               w_blink;
    logic [4*N_VIEW-1:0] r_bcd;
    logic [4*N_VIEW-1:0] w_bcd_nxt;
    bcd_t               w_dig [N_VIEW];

    blink_gen #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .restart(w_restart),
        .blink  (w_blink)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_win_nxt    = r_win;
        w_restart    = 1'b0;
        case (r_state)
            VIEW: begin
                // Entering edit takes priority; a coincident view_next is dropped.
                if (edit_en) begin
                    w_state_nxt  = EDIT;
                    w_cursor_nxt = CUR_MSD;
                    w_win_nxt    = f_win_of(N_DIGITS - 1);
                    w_restart    = 1'b1;
                end else if (view_next) begin
                    w_win_nxt = (r_win == WIN_LAST) ? '0 : r_win + 1'b1;
                end
            end
            EDIT: begin
                // Leaving edit wins over a coincident cursor move.
                if (!edit_en) begin
                    w_state_nxt = VIEW;
                end else begin
                    if (edit_next) begin
                        w_cursor_nxt = (r_cursor == '0) ? CUR_MSD
                                                        : r_cursor - 1'b1;
                        w_restart    = 1'b1;
                    end
                    w_win_nxt = f_win_of(int'(w_cursor_nxt));
                end
            end
            default: begin
                w_state_nxt = VIEW;
            end
        endcase
    end

    always_comb begin
        w_bcd_nxt = '0;
        for (int k = 0; k < N_VIEW; k++) begin
            w_dig[k] = bcd_in[4*(f_base(int'(r_win)) + k) +: 4];
            if (r_state == EDIT && !w_blink &&
                f_base(int'(r_win)) + k == int'(r_cursor)) begin
                w_dig[k] = BLANK_CODE;
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (r_state == VIEW && r_win == '0 &&
                k == N_VIEW - 1 && w_dig[k] == 4'h0) begin
                w_dig[k] = BLANK_CODE;
            end
`endif
            w_bcd_nxt[4*k +: 4] = w_dig[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= VIEW;
            r_win    <= '0;
            r_cursor <= CUR_MSD;
            r_bcd    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_win    <= w_win_nxt;
            r_cursor <= w_cursor_nxt;
            r_bcd    <= w_bcd_nxt;
        end
    end

    assign bcd_out  = r_bcd;
    assign win_idx  = r_win;
    assign blink    = w_blink;
    assign edit_sel = (r_state == EDIT) ? (N_DIGITS'(1) << r_cursor)
                                        : '0;

endmodule
